// File: rtl/demux_stream_1ton.sv
// demux_stream_1ton: registered 1-to-N valid/ready stream demultiplexer with one-deep channel registers.
// Optional macro DEMUX_STREAM_SEL_CHECK_EN builds a sticky out-of-range select error flag on o_err.
module demux_stream_1ton #(
   parameter int DATA_W = 8,
   parameter int CH_NUM = 4,
   parameter int SEL_W  = 2
) (
   input  logic                       i_clk,
   input  logic                       i_rst,
   input  logic [DATA_W-1:0]          i_data,
   input  logic [SEL_W-1:0]           i_sel,
   input  logic                       i_valid,
   output logic                       o_ready,
   output logic [CH_NUM*DATA_W-1:0]   o_data,
   output logic [CH_NUM-1:0]          o_valid,
   input  logic [CH_NUM-1:0]          i_ready,
   output logic                       o_err
);

   logic [CH_NUM-1:0]        sel_hit_s;
   logic [CH_NUM-1:0]        load_s;
   logic                     ready_s;
   logic [CH_NUM-1:0]        full_d;
   logic [CH_NUM-1:0]        full_q;
   logic [CH_NUM*DATA_W-1:0] data_d;
   logic [CH_NUM*DATA_W-1:0] data_q;

   // Select decode; an out-of-range select hits no channel and is therefore always accepted.
   always_comb begin
      sel_hit_s = '0;
      for (int c = 0; c < CH_NUM; c++) begin
         sel_hit_s[c] = (i_sel == SEL_W'(c));
      end
      ready_s = ~|(sel_hit_s & full_q & ~i_ready);
      load_s  = sel_hit_s & {CH_NUM{i_valid & ready_s}};
   end

   // Per-channel EMPTY/FULL next state: a load wins over a drain, so a full channel never bubbles.
   always_comb begin
      full_d = full_q;
      data_d = data_q;
      for (int c = 0; c < CH_NUM; c++) begin
         if (load_s[c]) begin
            full_d[c]                  = 1'b1;
            data_d[c*DATA_W +: DATA_W] = i_data;
         end else if (i_ready[c]) begin
            full_d[c] = 1'b0;
         end else begin
            full_d[c] = full_q[c];
         end
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         full_q <= '0;
         data_q <= '0;
      end else begin
         full_q <= full_d;
         data_q <= data_d;
      end
   end

   always_comb begin
      o_ready = ready_s;
      o_valid = full_q;
      o_data  = data_q;
   end

`ifdef DEMUX_STREAM_SEL_CHECK_EN
   logic err_d;
   logic err_q;

   // Out-of-range beats are always accepted, so i_valid alone qualifies the error.
   always_comb begin
      if (i_valid && (32'(i_sel) >= 32'(CH_NUM))) begin
         err_d = 1'b1;
      end else begin
         err_d = err_q;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_d;
      end
   end

   assign o_err = err_q;
`else
   assign o_err = 1'b0;
`endif

endmodule

// File: doc/demux_stream_1ton.md
# demux_stream_1ton

Registered, flow-controlled 1-to-N demultiplexer. It routes each input beat of `DATA_W` bits to one of `CH_NUM` output channels selected by `i_sel`. Every channel has a one-deep output register with a valid/ready handshake. This is the streaming generalisation of the combinational 1-to-4 demux and sits between a single producer and several independent consumers.

## Interface
- `DATA_W`, default 8: data width per beat.
- `CH_NUM`, default 4: number of output channels, 2..16.
- `SEL_W`, default 2: select width. Must satisfy `CH_NUM <= 2**SEL_W`.
- `i_clk`, input, 1: single clock. All state updates on the rising edge.
- `i_rst`, input, 1: reset, asynchronous and active-high.
- `i_data`, input, `DATA_W`: input beat.
- `i_sel`, input, `SEL_W`: destination channel index, sampled with the beat.
- `i_valid`, input, 1: input beat present.
- `o_ready`, output, 1: input beat accepted this cycle when high together with `i_valid`.
- `o_data`, output, `CH_NUM*DATA_W`: channel c occupies bits `[c*DATA_W +: DATA_W]`.
- `o_valid`, output, `CH_NUM`: per-channel output valid.
- `i_ready`, input, `CH_NUM`: per-channel consumer ready.
- `o_err`, output, 1: sticky flag for an out-of-range select (see Configuration).

## Operation
- Each channel c has a holding register `data[c]` and a flag `full[c]`. `o_valid[c]` is `full[c]`. `o_data` slice c is `data[c]`.
- **In-range select** (`i_sel < CH_NUM`): `o_ready = !full[i_sel] | i_ready[i_sel]`. This is combinational from `i_sel`, `full` and `i_ready`. It does not depend on `i_valid`.
- **Out-of-range select** (`i_sel >= CH_NUM`): `o_ready = 1`. The beat is consumed and discarded. No channel changes.
- **Accept** (`i_valid & o_ready`, in range): load `data[i_sel] <= i_data` and set `full[i_sel] <= 1`.
- **Drain**: when `full[c] & i_ready[c]` with no new load to c, clear `full[c]`.
- **Simultaneous drain and load on the same channel**: the new beat replaces the old one, `full` stays 1, and there is no bubble. This gives full throughput, one beat per cycle.
- Loads to one channel never disturb another channel's register or flag. A stalled channel blocks the input only while `i_sel` points at it.
- `data[c]` keeps its last value after a drain. Outputs are not forced to zero. Consumers qualify data with `o_valid`.
- While `o_valid[c] & !i_ready[c]`, `data[c]` and `o_valid[c]` are held stable.
- State per channel is either EMPTY or FULL:
  - EMPTY to FULL on accept.
  - FULL to EMPTY on drain without a load.
  - FULL to FULL on drain with a load, or on a stall.

## Timing
- Latency is 1 cycle. A beat accepted at edge k shows `o_valid[c]=1` with its data immediately after edge k.
- Reset, asynchronous on `i_rst` high:
  - `full` = 0, so `o_valid` = 0.
  - `data` = 0, so `o_data` = 0.
  - `o_err` = 0.
  - `o_ready` follows the combinational rule, so it reads 1 during reset because all channels are empty.
- Reset asserted mid-transfer discards every held beat immediately, without waiting for a clock edge.
- Beats presented during reset are not captured.
- The first accept is possible on the first rising edge after `i_rst` deasserts.
- The `i_ready` to `o_ready` path is combinational. A top-level pipeline stage is the integrator's responsibility.

## Configuration
- Macro: `DEMUX_STREAM_SEL_CHECK_EN`.
- **Defined**: an accepted out-of-range beat (`i_valid & i_sel >= CH_NUM`) sets `o_err` to 1 on that edge. It stays 1 until reset.
- **Not defined**: out-of-range beats are still consumed and dropped, `o_err` is tied to 0, and no comparator or flop is built.
- When `CH_NUM == 2**SEL_W`, both variants behave identically.

## Test plan
- **Reset.** Hold `i_rst=1` for 3 cycles, then release. Required: `o_valid=4'b0000`, `o_data=0`, `o_err=0`, `o_ready=1`.
- **Routing.** With all `i_ready=1`, send `i_data=8'hA0..8'hA3` with `i_sel=0..3` on consecutive cycles. Required: `o_valid[c]` pulses one cycle after each beat, with `data[c]=8'hA0+c`, and 4 beats complete in 4 cycles.
- **Backpressure.** Set `i_ready[2]=0` and send `8'h55` to channel 2, then `8'h66` to channel 2. Required:
  - `8'h55` is held stable and `o_ready=0` for the second beat.
  - A beat `8'h77` to channel 1 in the same stall window is accepted.
  - Raising `i_ready[2]` drains `8'h55`, then `8'h66`.
- **Drain and load on the same edge.** Channel 0 is FULL with `8'h11` and `i_ready[0]=1`. Send `8'h22` to channel 0. Required: `o_valid[0]` stays 1 and the data becomes `8'h22` on the next cycle.
- **Out-of-range select.** Use `CH_NUM=3`, `SEL_W=2`, and send `i_sel=3`, `i_data=8'hFF`. Required: `o_ready=1` and no `o_valid` change. `o_err` becomes 1 with the macro defined and stays 0 without it.
- **Mid-operation reset.** Fill channels 0 and 3 and assert `i_rst` between clock edges. Required: `o_valid` clears immediately, then normal operation resumes after release.
